data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 42 ++++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Shared size/sign types and the request/response bus of the data memory
// responder: the initiator drives requests and the responder answers them.
package dmem_pkg;
    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        LOAD_UNSIGNED = 1'b0,
        LOAD_SIGNED   = 1'b1
    } load_sign_t;
endpackage

interface data_mem_responder_if;
    import dmem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    mem_size_t   req_size;
    load_sign_t  req_sign;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size,
        output req_sign, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size,
        input  req_sign, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data RAM answering byte/half/word loads and stores.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic clk,
    input  logic rst_n,
    data_mem_responder_if.slave bus
);

    localparam int          WA    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [WA-1:0] idx;
    logic [WA-1:0] idx_q;
    logic [1:0]    lane_q;
    mem_size_t     size_q;
    load_sign_t    sign_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          is_byte;
    logic          is_half;
    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wlane;

    assign bus.req_ready = rst_n && (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign accept        = bus.req_valid && bus.req_ready;
    assign idx           = bus.req_addr[WA+1:2];

    always_comb begin
        is_byte = (bus.req_size == MEM_SIZE_BYTE);
        is_half = (bus.req_size == MEM_SIZE_HALF);
        // Range check on the full address so high bits never alias
        bad     = ({1'b0, bus.req_addr} >= LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (is_half && bus.req_addr[0])
            bad = 1'b1;
        if (!is_byte && !is_half && (bus.req_addr[1:0] != 2'b00))
            bad = 1'b1;
`endif
        be    = 4'b1111;
        wlane = bus.req_wdata;
        unique case (1'b1)
            is_byte: begin
                be    = 4'b0001 << bus.req_addr[1:0];
                wlane = {4{bus.req_wdata[7:0]}};
            end
            is_half: begin
                be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.req_wdata;
            end
        endcase
    end

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input mem_size_t   size,
        input load_sign_t  sign
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic        s;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        s = (sign == LOAD_SIGNED);
        unique case (1'b1)
            (size == MEM_SIZE_BYTE): extract = {{24{s & b[7]}}, b};
            (size == MEM_SIZE_HALF): extract = {{16{s & h[15]}}, h};
            default:                 extract = w;
        endcase
    endfunction

    // RAM has no reset so its contents survive rst_n
    always_ff @(posedge clk) begin
        if (accept && bus.req_write && !bad) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= MEM_SIZE_WORD;
            sign_q  <= LOAD_UNSIGNED;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rdata_q <= '0;
                        err_q   <= bad;
                        idx_q   <= idx;
                        lane_q  <= bus.req_addr[1:0];
                        size_q  <= bus.req_size;
                        sign_q  <= bus.req_sign;
                        state   <= (bad || bus.req_write) ? RESP : READ;
                    end
                end
                READ: begin
                    rdata_q <= extract(mem[idx_q], lane_q, size_q, sign_q);
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
